// File: rtl/fb_write_arbiter_if.sv
// Write-port bundle between the pixel requesters, the clear command and the frame-buffer write port.
// The arbiter uses the slave side. The requesters and the clear source use the master side.
interface fb_write_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 3
);
    logic          clr_start;
    logic          clr_busy;

    logic          req0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] data0;
    logic          ack0;

    logic          req1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] data1;
    logic          ack1;

    logic [AW-1:0] mem_px_addr;
    logic [DW-1:0] mem_px_data;
    logic          px_wr;

    modport master (
        output clr_start, req0, addr0, data0, req1, addr1, data1,
        input  clr_busy, ack0, ack1, mem_px_addr, mem_px_data, px_wr
    );

    modport slave (
        input  clr_start, req0, addr0, data0, req1, addr1, data1,
        output clr_busy, ack0, ack1, mem_px_addr, mem_px_data, px_wr
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter for the frame-buffer write port, shared by two requesters.
// It also contains a clear engine that fills the whole buffer with CLR_COLOR and locks out both requesters while it runs.
module fb_write_arbiter #(
    parameter int            AW        = 8,
    parameter int            DW        = 3,
    parameter logic [DW-1:0] CLR_COLOR = '0
) (
    input logic               clk,
    input logic               rst,
    fb_write_arbiter_if.slave bus
);
    typedef enum logic {ARB, CLEAR} state_t;

    state_t        state, state_next;
    logic [AW-1:0] clr_cnt, clr_cnt_next;
    logic          last_grant, last_grant_next;

    logic [AW-1:0] addr_next;
    logic [DW-1:0] data_next;
    logic          wr_next, ack0_next, ack1_next, busy_next;

    logic          elig0, elig1, grant0, grant1, start;

    // A requester whose ack is still high has not yet dropped or updated its request.
    assign elig0  = bus.req0 & ~bus.ack0;
    assign elig1  = bus.req1 & ~bus.ack1;
    assign grant0 = elig0 & (~elig1 | last_grant);
    assign grant1 = elig1 & (~elig0 | ~last_grant);
    // The busy flag stays high during the last clear write, so a pulse arriving in that cycle is dropped.
    assign start  = bus.clr_start & ~bus.clr_busy;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= ARB;
            clr_cnt         <= '0;
            last_grant      <= 1'b1;
            bus.px_wr       <= 1'b0;
            bus.ack0        <= 1'b0;
            bus.ack1        <= 1'b0;
            bus.clr_busy    <= 1'b0;
            bus.mem_px_addr <= '0;
            bus.mem_px_data <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register here samples values from before the edge.
            state           <= state_next;
            clr_cnt         <= clr_cnt_next;
            last_grant      <= last_grant_next;
            bus.px_wr       <= wr_next;
            bus.ack0        <= ack0_next;
            bus.ack1        <= ack1_next;
            bus.clr_busy    <= busy_next;
            bus.mem_px_addr <= addr_next;
            bus.mem_px_data <= data_next;
        end
    end

    // Next state
    always_comb begin
        state_next = state;
        case (state)
            ARB:     if (start) state_next = CLEAR;
            CLEAR:   if (clr_cnt == '1) state_next = ARB;
            default: state_next = ARB;
        endcase
    end

    // Next output values
    always_comb begin
        // NOTE: every signal gets a default first, so no path through this block leaves it unassigned and no latch is inferred.
        wr_next         = 1'b0;
        ack0_next       = 1'b0;
        ack1_next       = 1'b0;
        busy_next       = 1'b0;
        addr_next       = bus.mem_px_addr;
        data_next       = bus.mem_px_data;
        clr_cnt_next    = clr_cnt;
        last_grant_next = last_grant;

        if (state == CLEAR) begin
            wr_next      = 1'b1;
            busy_next    = 1'b1;
            addr_next    = clr_cnt;
            data_next    = CLR_COLOR;
            clr_cnt_next = clr_cnt + AW'(1);
        end else if (!start) begin
            if (grant0) begin
                wr_next         = 1'b1;
                ack0_next       = 1'b1;
                addr_next       = bus.addr0;
                data_next       = bus.data0;
                last_grant_next = 1'b0;
            end else if (grant1) begin
                wr_next         = 1'b1;
                ack1_next       = 1'b1;
                addr_next       = bus.addr1;
                data_next       = bus.data1;
                last_grant_next = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Testbench for fb_write_arbiter, built with AW=4 and CLR_COLOR=3'b010.
// Directed scenarios first, then randomized traffic checked against a reference model written from the arbitration rules.
module tb_fb_write_arbiter;
    localparam int            AW    = 4;
    localparam int            DW    = 3;
    localparam logic [DW-1:0] CLR   = 3'b010;
    localparam int            DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fb_write_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    fb_write_arbiter #(.AW(AW), .DW(DW), .CLR_COLOR(CLR)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    // Reference model. m_* hold the outputs expected after the latest edge.
    bit m_wr, m_ack0, m_ack1, m_busy;
    int m_addr, m_data;
    int m_last;   // requester granted most recently
    int m_clr;    // next clear address to write, or -1 when no clear is running

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_edge();
        bit n_wr, n_a0, n_a1, n_busy, e0, e1;
        int n_addr, n_data, g;
        n_wr = 0; n_a0 = 0; n_a1 = 0; n_busy = 0;
        n_addr = m_addr; n_data = m_data; g = -1;
        if (!rst) begin
            m_wr = 0; m_ack0 = 0; m_ack1 = 0; m_busy = 0;
            m_addr = 0; m_data = 0; m_last = 1; m_clr = -1;
            return;
        end
        if (m_clr >= 0) begin
            n_wr = 1; n_busy = 1; n_addr = m_clr; n_data = int'(CLR);
            m_clr = (m_clr == DEPTH - 1) ? -1 : m_clr + 1;
        end else if (bus.clr_start && !m_busy) begin
            m_clr = 0;
        end else begin
            e0 = bus.req0 && !m_ack0;
            e1 = bus.req1 && !m_ack1;
            if (e0 && e1)  g = 1 - m_last;
            else if (e0)   g = 0;
            else if (e1)   g = 1;
            if (g == 0) begin n_wr = 1; n_a0 = 1; n_addr = int'(bus.addr0); n_data = int'(bus.data0); end
            if (g == 1) begin n_wr = 1; n_a1 = 1; n_addr = int'(bus.addr1); n_data = int'(bus.data1); end
            if (g >= 0) m_last = g;
        end
        m_wr = n_wr; m_ack0 = n_a0; m_ack1 = n_a1; m_busy = n_busy;
        m_addr = n_addr; m_data = n_data;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        bus.req0 = 1'b1; bus.addr0 = 4'h5; bus.data0 = 3'b111;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({bus.px_wr, bus.ack0, bus.ack1, bus.clr_busy} !== 4'b0000 || bus.mem_px_addr !== 4'h0) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: wr/ack0/ack1/busy=%b addr=%h, expected 0000 addr=0",
                         i, {bus.px_wr, bus.ack0, bus.ack1, bus.clr_busy}, bus.mem_px_addr);
            end
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (bus.px_wr !== 1'b1 || bus.ack0 !== 1'b1 || bus.mem_px_addr !== 4'h5) begin
            n_err++;
            $display("FAIL reset_first_grant: wr=%b ack0=%b addr=%h, expected 1 1 5", bus.px_wr, bus.ack0, bus.mem_px_addr);
        end
        bus.req0 = 1'b0;
        tick(); tick();
    endtask

    task automatic test_single_write();
        logic [2:0] got;
        bus.req0 = 1'b1; bus.addr0 = 4'h5; bus.data0 = 3'b111;
        for (int i = 0; i < 4; i++) begin
            tick();
            got = {bus.px_wr, bus.ack0, bus.ack1};
            n_cmp++;
            if (got !== ((i % 2 == 0) ? 3'b110 : 3'b000) ||
                (i % 2 == 0 && (bus.mem_px_addr !== 4'h5 || bus.mem_px_data !== 3'b111))) begin
                n_err++;
                $display("FAIL single_write[%0d]: wr/ack0/ack1=%b addr=%h data=%b, expected %b addr=5 data=111",
                         i, got, bus.mem_px_addr, bus.mem_px_data, (i % 2 == 0) ? 3'b110 : 3'b000);
            end
        end
        bus.req0 = 1'b0;
        tick(); tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_addr;
        rst = 1'b0; tick(); rst = 1'b1;
        bus.req0 = 1'b1; bus.addr0 = 4'hA; bus.data0 = 3'b001;
        bus.req1 = 1'b1; bus.addr1 = 4'h2; bus.data1 = 3'b110;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_addr = (i % 2 == 0) ? 4'hA : 4'h2;
            n_cmp++;
            if (bus.px_wr !== 1'b1 || bus.ack0 !== (i % 2 == 0) || bus.ack1 !== (i % 2 == 1) ||
                bus.mem_px_addr !== exp_addr) begin
                n_err++;
                $display("FAIL round_robin[%0d]: wr=%b ack0=%b ack1=%b addr=%h, expected wr=1 addr=%h",
                         i, bus.px_wr, bus.ack0, bus.ack1, bus.mem_px_addr, exp_addr);
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick(); tick();
    endtask

    task automatic test_clear();
        bus.req1 = 1'b1; bus.addr1 = 4'h3; bus.data1 = 3'b101;
        bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        n_cmp++;
        if (bus.px_wr !== 1'b0 || bus.clr_busy !== 1'b0 || bus.ack1 !== 1'b0) begin
            n_err++;
            $display("FAIL clear_start_edge: wr=%b busy=%b ack1=%b, expected 0 0 0", bus.px_wr, bus.clr_busy, bus.ack1);
        end
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            n_cmp++;
            if ({bus.px_wr, bus.clr_busy, bus.ack0, bus.ack1} !== 4'b1100 ||
                bus.mem_px_addr !== AW'(k) || bus.mem_px_data !== CLR) begin
                n_err++;
                $display("FAIL clear_write[%0d]: wr/busy/ack0/ack1=%b addr=%h data=%b, expected 1100 addr=%h data=%b",
                         k, {bus.px_wr, bus.clr_busy, bus.ack0, bus.ack1}, bus.mem_px_addr, bus.mem_px_data, AW'(k), CLR);
            end
        end
        tick();
        n_cmp++;
        if (bus.clr_busy !== 1'b0 || bus.ack1 !== 1'b1 || bus.px_wr !== 1'b1 ||
            bus.mem_px_addr !== 4'h3 || bus.mem_px_data !== 3'b101) begin
            n_err++;
            $display("FAIL clear_then_grant: busy=%b ack1=%b wr=%b addr=%h data=%b, expected 0 1 1 3 101",
                     bus.clr_busy, bus.ack1, bus.px_wr, bus.mem_px_addr, bus.mem_px_data);
        end
        bus.req1 = 1'b0;
        tick(); tick();
    endtask

    task automatic test_clear_conflicts();
        int busy_cycles = 0;
        int early_acks = 0;
        bus.req0 = 1'b1; bus.addr0 = 4'h9; bus.data0 = 3'b011;
        bus.clr_start = 1'b1;
        tick();
        n_cmp++;
        if (bus.ack0 !== 1'b0 || bus.px_wr !== 1'b0) begin
            n_err++;
            $display("FAIL conflict_clear_wins: ack0=%b wr=%b, expected 0 0", bus.ack0, bus.px_wr);
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            bus.clr_start = (cyc == 5);
            tick();
            if (!bus.clr_busy) break;
            busy_cycles++;
            if (bus.ack0) early_acks++;
        end
        bus.clr_start = 1'b0;
        n_cmp++;
        if (busy_cycles !== DEPTH) begin
            n_err++;
            $display("FAIL conflict_clear_length: busy cycles=%0d, expected %0d", busy_cycles, DEPTH);
        end
        n_cmp++;
        if (early_acks !== 0 || bus.ack0 !== 1'b1 || bus.mem_px_addr !== 4'h9) begin
            n_err++;
            $display("FAIL conflict_req_after_clear: acks during clear=%0d ack0=%b addr=%h, expected 0 1 9",
                     early_acks, bus.ack0, bus.mem_px_addr);
        end
        bus.req0 = 1'b0;
        tick(); tick();
        n_cmp++;
        if (bus.px_wr !== 1'b0 || bus.clr_busy !== 1'b0) begin
            n_err++;
            $display("FAIL conflict_no_extension: wr=%b busy=%b, expected 0 0", bus.px_wr, bus.clr_busy);
        end
    endtask

    task automatic test_reset_mid_clear();
        bit found = 0;
        int writes = 0;
        bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (bus.clr_busy && bus.mem_px_addr == 4'h7) found = 1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL midclear_reach_addr7: address 7 not observed within 40 cycles, expected it");
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (bus.px_wr !== 1'b0 || bus.clr_busy !== 1'b0) begin
            n_err++;
            $display("FAIL midclear_abort: wr=%b busy=%b, expected 0 0", bus.px_wr, bus.clr_busy);
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.px_wr) writes++;
        end
        n_cmp++;
        if (writes !== 0) begin
            n_err++;
            $display("FAIL midclear_no_resume: writes after release=%0d, expected 0", writes);
        end
        bus.req1 = 1'b1; bus.addr1 = 4'hE; bus.data1 = 3'b100;
        tick();
        n_cmp++;
        if (bus.ack1 !== 1'b1 || bus.px_wr !== 1'b1 || bus.mem_px_addr !== 4'hE) begin
            n_err++;
            $display("FAIL midclear_arb_resumes: ack1=%b wr=%b addr=%h, expected 1 1 e", bus.ack1, bus.px_wr, bus.mem_px_addr);
        end
        bus.req1 = 1'b0;
        tick(); tick();
    endtask

    task automatic test_random(input int cycles);
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.clr_start = 1'b0;
        rst = 1'b0;
        model_edge();
        tick();
        rst = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            // Each requester follows the handshake: hold until acked, then drop or present the next pixel.
            if (bus.req0 && bus.ack0) begin
                if ($urandom_range(0, 1) == 0) bus.req0 = 1'b0;
                else begin bus.addr0 = AW'($urandom); bus.data0 = DW'($urandom); end
            end else if (!bus.req0 && $urandom_range(0, 2) == 0) begin
                bus.req0 = 1'b1; bus.addr0 = AW'($urandom); bus.data0 = DW'($urandom);
            end
            if (bus.req1 && bus.ack1) begin
                if ($urandom_range(0, 1) == 0) bus.req1 = 1'b0;
                else begin bus.addr1 = AW'($urandom); bus.data1 = DW'($urandom); end
            end else if (!bus.req1 && $urandom_range(0, 2) == 0) begin
                bus.req1 = 1'b1; bus.addr1 = AW'($urandom); bus.data1 = DW'($urandom);
            end
            bus.clr_start = ($urandom_range(0, 99) == 0);
            rst = ($urandom_range(0, 399) != 0);
            model_edge();
            tick();
            n_cmp++;
            if ({bus.px_wr, bus.ack0, bus.ack1, bus.clr_busy} !== {m_wr, m_ack0, m_ack1, m_busy} ||
                bus.mem_px_addr !== AW'(m_addr) || bus.mem_px_data !== DW'(m_data)) begin
                n_err++;
                $display("FAIL random[%0d]: wr/ack0/ack1/busy=%b addr=%h data=%b, expected %b addr=%h data=%b",
                         c, {bus.px_wr, bus.ack0, bus.ack1, bus.clr_busy}, bus.mem_px_addr, bus.mem_px_data,
                         {m_wr, m_ack0, m_ack1, m_busy}, AW'(m_addr), DW'(m_data));
            end
        end
        rst = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.clr_start = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        bus.clr_start = 1'b0;
        bus.req0 = 1'b0; bus.addr0 = '0; bus.data0 = '0;
        bus.req1 = 1'b0; bus.addr1 = '0; bus.data1 = '0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_clear();
        test_clear_conflicts();
        test_reset_mid_clear();
        test_random(3000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Write-port arbiter and screen-clear sequencer for the VGA pixel frame buffer. Two independent requesters share the single pixel-memory write port through a req/ack handshake, for example the game FSM and a sprite/score drawer. Sharing is round-robin. A built-in clear engine fills the whole buffer with a background colour on command and locks out both requesters while it runs. The block sits between the game-logic modules and the frame-buffer memory that the VGA scan reads.

## Interface
- AW, 8, pixel-memory address width; buffer depth is 2**AW pixels
- DW, 3, pixel data width (RGB bits)
- CLR_COLOR, 3'b000, colour written by the clear engine (DW bits)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- clr_start  in  1  one-cycle pulse that requests a full-buffer clear
- clr_busy  out  1  high while the clear engine owns the port
- req0  in  1  requester 0 write request; held until ack0
- addr0  in  AW  requester 0 pixel address
- data0  in  DW  requester 0 pixel data
- ack0  out  1  one-cycle pulse: requester 0 write is being performed
- req1  in  1  requester 1 write request; held until ack1
- addr1  in  AW  requester 1 pixel address
- data1  in  DW  requester 1 pixel data
- ack1  out  1  one-cycle pulse: requester 1 write is being performed
- mem_px_addr  out  AW  frame-buffer write address
- mem_px_data  out  DW  frame-buffer write data
- px_wr  out  1  frame-buffer write enable

## Operation
- **States:** ARB and CLEAR.
- **Reset** (rst=0 at a rising edge):
  - state=ARB.
  - px_wr, ack0, ack1 and clr_busy = 0.
  - mem_px_addr=0, mem_px_data=0.
  - Clear counter = 0.
  - Round-robin pointer set so requester 0 wins the first tie.
- **ARB, priority order each cycle:**
  1. clr_start=1: go to CLEAR. No grant this cycle.
  2. Otherwise, among eligible requesters, grant one. Requester i is eligible when req_i=1 and ack_i=0. The ack_i=0 condition blocks a double write while the requester is still dropping req.
  3. If both are eligible, grant the requester not granted last. Then update the pointer.
  4. If none is eligible, px_wr=0.
- **Grant of i:** the next outputs are mem_px_addr=addr_i, mem_px_data=data_i, px_wr=1, ack_i=1, and the other ack=0.
- **Requester rule:** hold req_i, addr_i and data_i stable until ack_i is sampled high. Then drop req_i or present the next pixel.
- **CLEAR:**
  - Each cycle, write CLR_COLOR to address = counter, with px_wr=1, clr_busy=1, ack0=ack1=0.
  - The counter increments modulo 2**AW.
  - After writing address 2**AW-1: counter returns to 0, state goes to ARB, clr_busy falls.
- **In CLEAR:** clr_start is ignored, and requests stay pending; they are neither acked nor lost.
- **Reset during CLEAR:** aborts immediately. The clear does not resume after reset release.
- **Address/width rules:**
  - Addresses are used unmodified (no bounds check). The counter is exactly AW bits.
  - CLR_COLOR is truncated/zero-extended to DW.

## Timing
- All outputs are registered, and change only at rising edges.
- **Write latency:** req_i is sampled high at edge N → px_wr, address, data and ack_i are valid from edge N to edge N+1. That is one cycle of latency, and ack lasts exactly one cycle.
- **Single-requester throughput:** with req_i held continuously, writes occur at most every 2 cycles.
- **Two-requester throughput:** with both held, grants alternate 0,1,0,1 and px_wr is high every cycle.
- **Clear timing:**
  - clr_start sampled at edge N → first clear write (address 0) and clr_busy=1 from edge N+1.
  - The last write (address 2**AW-1) is at cycle N+2**AW.
  - clr_busy=0 and ARB from edge N+2**AW+1. That edge can also issue the first pending grant.
- **Total clear:** exactly 2**AW write cycles with no gaps.
- **Simultaneous events:**
  - clr_start and a request in the same cycle: the clear wins, and the request is served after the clear.
  - A clr_start pulse during clr_busy is dropped, not queued.

## Test plan
- **Reset:** hold rst=0 for 2 cycles with req0=1 → px_wr=0, ack0=ack1=0, clr_busy=0, mem_px_addr=0 throughout. The first grant comes one cycle after release.
- **Single write:** req0=1, addr0=8'h05, data0=3'b111 → the next cycle has px_wr=1, mem_px_addr=8'h05, mem_px_data=3'b111, ack0=1 for one cycle. With req0 held, px_wr pulses every other cycle.
- **Round-robin:** req0 and req1 both held, with addr0=8'h10 and addr1=8'h20 → mem_px_addr sequence is 10,20,10,20 and px_wr is high every cycle; ack0 and ack1 alternate and never overlap.
- **Clear with AW=4, CLR_COLOR=3'b010:**
  - Stimulus: pulse clr_start while req1 is held.
  - Response: clr_busy is high for 16 cycles, and addresses 0..15 are written with 3'b010. ack1 stays 0 until clr_busy falls, then ack1 is granted on the very next edge.
- **Clear conflicts:**
  - clr_start in the same cycle as a new req0 → the clear starts first, and req0 is acked after the clear.
  - A second clr_start pulse mid-clear → no extension; still exactly 16 writes.
- **Reset mid-clear:** assert rst=0 when mem_px_addr=7 → the next edge gives px_wr=0, clr_busy=0. After release, no further clear writes occur, and normal arbitration resumes.
